rst_ctrl: RTL and testbench

- Parametrised reset manager for NUM_DOM reset domains, e.g. core, SPI slave, DMA/PIM.
- Per domain: asynchronous-assert, synchronous-release synchronisation; release ordered by domain index with a programmable gap; software-triggered reset with a fixed hold time.
- Sticky reset-cause capture, readable and clearable through a bus slave port (same protocol as the SRAM/UART slaves).
- Derives the shared bus reset from a mask of domains.

---
 rtl/rst_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rst_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_ctrl.sv
// Reset manager for NUM_DOM reset domains.
// Each domain has its own synchroniser. Requests assert asynchronously and
// release synchronously. Releases are ordered by domain index, with a gap
// between consecutive releases. The block also provides software resets, a
// sticky reset-cause register and a bus reset derived from a domain mask.
//
// Bus handshake: i_write and i_read are single-cycle strobes with no
// back-pressure (there is no ready). A write takes effect at the rising edge
// that samples i_write. Read data appears on o_dout the cycle after i_read is
// sampled, and holds its value while i_read is low.
module rst_ctrl #(
  parameter int                  XLEN          = 32,
  parameter int                  NUM_DOM       = 3,
  parameter int                  SYNC_STAGES   = 5,
  parameter int                  RELEASE_GAP   = 4,
  parameter int                  SW_RST_CYCLES = 16,
  parameter logic [NUM_DOM-1:0]  BUS_MASK      = NUM_DOM'(3'b011),
  parameter logic [XLEN-1:0]     BASE_ADDR     = XLEN'(32'h8000_0100)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_DOM-1:0]     i_rst_req_n,
  input  logic [XLEN-1:0]        i_addr,
  input  logic                   i_write,
  input  logic                   i_read,
  input  logic [3:0]             i_size,
  input  logic [XLEN-1:0]        i_din,
  output logic [XLEN-1:0]        o_dout,
  output logic [NUM_DOM-1:0]     o_rst_n,
  output logic                   o_bus_rst_n,
  output logic                   o_busy,
  output logic [2*NUM_DOM-1:0]   o_dbg_state
);

  localparam int HW = $clog2(SW_RST_CYCLES + 1);
  localparam int GW = $clog2(RELEASE_GAP + 2);

  localparam logic [XLEN-1:0] ADDR_CTRL  = BASE_ADDR;
  localparam logic [XLEN-1:0] ADDR_STAT  = BASE_ADDR + XLEN'(4);
  localparam logic [XLEN-1:0] ADDR_CAUSE = BASE_ADDR + XLEN'(8);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } dom_state_e;

  dom_state_e           state_q [NUM_DOM];
  dom_state_e           state_d [NUM_DOM];
  logic [HW-1:0]        hold_q  [NUM_DOM];
  logic [HW-1:0]        hold_d  [NUM_DOM];
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_DOM-1:0]   sync_ok;
  logic [NUM_DOM-1:0]   rst_q;
  logic [NUM_DOM-1:0]   run_d;
  logic [NUM_DOM-1:0]   rel_sel;
  logic                 arb_blocked;
  logic [XLEN-1:0]      be_mask, wdata;
  logic [NUM_DOM-1:0]   sw_wr;
  logic [XLEN-1:0]      cause_q, cause_d, cause_set, cause_clr;
  logic [XLEN-1:0]      rd_data, stat_word, dout_q;

  // Per-domain synchroniser and output flop. Both are cleared directly by the
  // combined request, so a request shorter than a clock still resets the domain.
  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    logic                   dom_arst_n;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rst_ff;

    assign dom_arst_n = i_rst_n & i_rst_req_n[d];

    // Shift ones in once the request is gone; the last stage is sync_ok.
    always_ff @(posedge i_clk or negedge dom_arst_n) begin
      if (!dom_arst_n) sync_ff <= '0;
      else             sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
    end

    // Domain reset output: high only while the domain FSM is in RUN.
    always_ff @(posedge i_clk or negedge dom_arst_n) begin
      if (!dom_arst_n) rst_ff <= 1'b0;
      else             rst_ff <= run_d[d];
    end

    assign sync_ok[d] = sync_ff[SYNC_STAGES-1];
    assign rst_q[d]   = rst_ff;
  end

  // Bus decode: byte-enabled write data, CTRL software-reset bits, CAUSE W1C bits.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) be_mask[b*8 +: 8] = {8{i_size[b]}};
    wdata     = i_din & be_mask;
    sw_wr     = (i_write && i_addr == ADDR_CTRL)  ? wdata[NUM_DOM-1:0] : '0;
    cause_clr = (i_write && i_addr == ADDR_CAUSE) ? wdata : '0;
  end

  // Release arbiter: only the first domain that is not in RUN can be released.
  // A domain that became ready this cycle (RST with sync_ok and hold done)
  // counts as waiting, so power-on release needs no extra cycle.
  always_comb begin
    rel_sel     = '0;
    arb_blocked = 1'b0;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (!arb_blocked && state_q[d] != ST_RUN) begin
        arb_blocked = 1'b1;
        if (gap_q == '0 && sync_ok[d] && hold_q[d] == '0 && !sw_wr[d] &&
            (state_q[d] == ST_WAIT || state_q[d] == ST_RST))
          rel_sel[d] = 1'b1;
      end
    end
    gap_d = gap_q;
    if (|rel_sel)          gap_d = GW'(RELEASE_GAP);
    else if (gap_q != '0)  gap_d = gap_q - GW'(1);
  end

  // Per-domain next state. Software reset wins, then loss of sync_ok, then
  // normal progress. The hold counter keeps running even in RST.
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      state_d[d] = state_q[d];
      hold_d[d]  = (hold_q[d] != '0) ? hold_q[d] - HW'(1) : hold_q[d];
      if (sw_wr[d]) begin
        hold_d[d]  = HW'(SW_RST_CYCLES);
        state_d[d] = sync_ok[d] ? ST_HOLD : ST_RST;
      end else if (!sync_ok[d]) begin
        state_d[d] = ST_RST;
      end else begin
        case (state_q[d])
          ST_RST:  if (rel_sel[d]) state_d[d] = ST_RUN;
                   else if (hold_q[d] == '0) state_d[d] = ST_WAIT;
          ST_HOLD: if (hold_q[d] <= HW'(1)) state_d[d] = ST_WAIT;
          ST_WAIT: if (rel_sel[d]) state_d[d] = ST_RUN;
          default: state_d[d] = ST_RUN;
        endcase
      end
      run_d[d] = (state_d[d] == ST_RUN);
    end
  end

  // Cause set/clear and read mux; a set on the same cycle as a clear wins.
  always_comb begin
    cause_set = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      cause_set[d]      = (state_q[d] == ST_RUN) && !sync_ok[d];
      cause_set[16 + d] = sw_wr[d];
    end
    cause_d = (cause_q & ~cause_clr) | cause_set;

    stat_word               = '0;
    stat_word[NUM_DOM-1:0]  = rst_q;
    stat_word[XLEN-1]       = ~&rst_q;
    if (i_addr == ADDR_STAT)       rd_data = stat_word;
    else if (i_addr == ADDR_CAUSE) rd_data = cause_q;
    else                           rd_data = '0;
  end

  // Control state: only the power-on reset clears it, never a domain reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= ST_RST;
        hold_q[d]  <= '0;
      end
      gap_q   <= '0;
      cause_q <= '0;
      dout_q  <= '0;
    end else begin
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= state_d[d];
        hold_q[d]  <= hold_d[d];
      end
      gap_q   <= gap_d;
      cause_q <= cause_d;
      if (i_read) dout_q <= rd_data;
    end
  end

  // Outputs and FSM state visibility.
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) o_dbg_state[2*d +: 2] = state_q[d];
  end

  assign o_rst_n     = rst_q;
  assign o_bus_rst_n = |(rst_q & BUS_MASK);
  assign o_busy      = ~&rst_q;
  assign o_dout      = dout_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Testbench for rst_ctrl: directed scenarios plus random bus and reset-request
// traffic, checked against a timeline-level reference model.
module tb_rst_ctrl;

  localparam int          ND    = 3;
  localparam int          S     = 5;
  localparam int          GAP   = 4;
  localparam int          SWC   = 16;
  localparam logic [2:0]  BUSM  = 3'b011;
  localparam logic [31:0] A_CTRL  = 32'h8000_0100;
  localparam logic [31:0] A_STAT  = 32'h8000_0104;
  localparam logic [31:0] A_CAUSE = 32'h8000_0108;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [ND-1:0] i_rst_req_n;
  logic [31:0]   i_addr;
  logic          i_write;
  logic          i_read;
  logic [3:0]    i_size;
  logic [31:0]   i_din;
  logic [31:0]   o_dout;
  logic [ND-1:0] o_rst_n;
  logic          o_bus_rst_n;
  logic          o_busy;
  logic [2*ND-1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: per-domain "edges until synchronised", remaining hold
  // time, running flag, and a timestamp of the earliest next release.
  int          m_sync [ND];
  int          m_hold [ND];
  bit          m_run  [ND];
  logic [ND-1:0] m_out;
  logic [31:0] m_cause, m_dout;
  longint      m_cycle = 0;
  longint      m_next_ok = 0;

  rst_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rst_req_n(i_rst_req_n),
    .i_addr(i_addr), .i_write(i_write), .i_read(i_read), .i_size(i_size),
    .i_din(i_din), .o_dout(o_dout), .o_rst_n(o_rst_n),
    .o_bus_rst_n(o_bus_rst_n), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_sync[d] = S; m_hold[d] = 0; m_run[d] = 1'b0;
    end
    m_out = '0; m_cause = '0; m_dout = '0; m_next_ok = 0;
  endfunction

  // An asynchronous request drops the domain output at once and restarts its
  // synchroniser count.
  function automatic void model_async(input int d);
    m_out[d]  = 1'b0;
    m_sync[d] = S;
  endfunction

  function automatic void model_tick();
    logic [31:0]   mask, wd, clr;
    logic [ND-1:0] sw;
    int            rel;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{i_size[b]}};
    wd  = i_din & mask;
    sw  = (i_write && i_addr == A_CTRL)  ? wd[ND-1:0] : '0;
    clr = (i_write && i_addr == A_CAUSE) ? wd : 32'd0;
    if (i_read)
      m_dout = (i_addr == A_STAT)  ? {~&m_out, 28'd0, m_out} :
               (i_addr == A_CAUSE) ? m_cause : 32'd0;
    rel = -1;
    for (int d = 0; d < ND; d++) begin
      if (!m_run[d]) begin
        if (m_sync[d] == 0 && m_hold[d] == 0 && !sw[d] && m_cycle >= m_next_ok) rel = d;
        break;
      end
    end
    m_cause = m_cause & ~clr;
    for (int d = 0; d < ND; d++) begin
      if (m_sync[d] != 0 && m_run[d]) m_cause[d] = 1'b1;
      if (sw[d]) m_cause[16 + d] = 1'b1;
    end
    for (int d = 0; d < ND; d++) begin
      if (m_sync[d] != 0) m_run[d] = 1'b0;
      if (sw[d]) begin
        m_run[d] = 1'b0; m_out[d] = 1'b0; m_hold[d] = SWC;
      end else if (m_hold[d] > 0) m_hold[d]--;
      if (!i_rst_req_n[d]) m_sync[d] = S;
      else if (m_sync[d] > 0) m_sync[d]--;
    end
    if (rel >= 0) begin
      m_run[rel] = 1'b1; m_out[rel] = 1'b1;
      m_next_ok = m_cycle + GAP + 1;
    end
    m_cycle++;
  endfunction

  always @(posedge i_clk) model_tick();

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_rst_n"}, 32'(o_rst_n), 32'(m_out));
    check({tag, "_bus"}, 32'(o_bus_rst_n), 32'(|(m_out & BUSM)));
    check({tag, "_busy"}, 32'(o_busy), 32'(~&m_out));
    check({tag, "_dout"}, o_dout, m_dout);
  endtask

  // driver tasks
  task automatic tick();
    @(negedge i_clk);
    check_outs("cyc");
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
    i_addr = a; i_din = v; i_size = be; i_write = 1'b1;
    tick();
    i_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    i_addr = a; i_read = 1'b1;
    tick();
    i_read = 1'b0;
  endtask

  task automatic glitch(input int d);
    i_rst_req_n[d] = 1'b0;
    model_async(d);
    #1 check_outs("glitch");
    #1 i_rst_req_n[d] = 1'b1;
  endtask

  // Counts ticks until o_rst_n[d] is high, bounded.
  task automatic wait_high(input int d, output int n);
    n = 0;
    while (!o_rst_n[d] && n < 60) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return A_CTRL;
      1: return A_STAT;
      2: return A_CAUSE;
      3: return 32'h8000_010C;
      4: return 32'h8000_0102;
      default: return 32'h0000_0100;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] a;
    i_rst_n = 1'b0; i_rst_req_n = '1; i_addr = '0; i_write = 1'b0;
    i_read = 1'b0; i_size = 4'hF; i_din = '0;
    model_reset();
    repeat (3) @(negedge i_clk);

    // Reset values
    check("reset_rst_n", 32'(o_rst_n), 32'h0);
    check("reset_bus", 32'(o_bus_rst_n), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h1);
    check("reset_dout", o_dout, 32'h0);

    // Power-on: the first edge with i_rst_n high is cycle 0; tick k shows cycle k-1.
    i_rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5)  check("por_c4", 32'(o_rst_n), 32'b000);
      if (k == 6)  check("por_c5", 32'(o_rst_n), 32'b001);
      if (k == 11) check("por_c10", 32'(o_rst_n), 32'b011);
      if (k == 16) check("por_c15", 32'(o_rst_n), 32'b111);
    end

    // External glitch on domain 1 while everything runs
    glitch(1);
    check("glitch_d1_low", 32'(o_rst_n), 32'b101);
    wait_high(1, n);
    check("glitch_release_ticks", n, 6);
    repeat (3) tick();
    bus_read(A_CAUSE);
    check("glitch_cause", o_dout, 32'h0000_0002);
    bus_write(A_CAUSE, 32'hFFFF_FFFF, 4'hF);

    // Software reset of domain 2
    bus_write(A_CTRL, 32'h4, 4'hF);
    check("sw_d2_low", 32'(o_rst_n), 32'b011);
    wait_high(2, n);
    check("sw_hold_ticks", n, 17);
    bus_read(A_CAUSE);
    check("sw_cause", o_dout, 32'h0004_0000);
    bus_write(A_CAUSE, 32'h0004_0000, 4'hF);
    bus_read(A_CAUSE);
    check("sw_cause_clr", o_dout, 32'h0);

    // Ordering: domain 2 waits for domain 0
    i_rst_req_n[0] = 1'b0;
    model_async(0);
    repeat (3) tick();
    glitch(2);
    repeat (10) tick();
    check("order_d2_blocked", 32'(o_rst_n), 32'b010);
    i_rst_req_n[0] = 1'b1;
    wait_high(0, n);
    check("order_d0_ticks", n, 6);
    wait_high(2, n);
    check("order_d2_gap", n, GAP + 1);
    bus_write(A_CAUSE, 32'hFFFF_FFFF, 4'hF);

    // Set wins over a simultaneous W1C
    i_addr = A_CAUSE; i_din = 32'h2; i_size = 4'hF; i_write = 1'b1;
    glitch(1);
    tick();
    i_write = 1'b0;
    repeat (10) tick();
    bus_read(A_CAUSE);
    check("setclr_cause", o_dout, 32'h0000_0002);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: tick();
        4, 5: bus_read(pick_addr());
        6: begin
          a = pick_addr();
          bus_write(a, (a == A_CTRL) ? 32'($urandom_range(0, 15)) : $urandom,
                    4'($urandom_range(0, 15)));
        end
        7: glitch($urandom_range(0, ND - 1));
        default: begin
          n = $urandom_range(0, ND - 1);
          i_rst_req_n[n] = 1'b0;
          model_async(n);
          repeat ($urandom_range(1, 8)) tick();
          i_rst_req_n[n] = 1'b1;
        end
      endcase
    end
    repeat (40) tick();

    // i_rst_n drop while domain 1 waits for its release slot
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (7) tick();
    bus_read(A_STAT);
    #1 i_rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_n", 32'(o_rst_n), 32'h0);
    check("mid_bus", 32'(o_bus_rst_n), 32'h0);
    check("mid_busy", 32'(o_busy), 32'h1);
    check("mid_dout", o_dout, 32'h0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 6)  check("restart_c5", 32'(o_rst_n), 32'b001);
      if (k == 16) check("restart_c15", 32'(o_rst_n), 32'b111);
    end
    bus_read(A_CAUSE);
    check("restart_cause", o_dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
